hilo_muldiv_alu: RTL and testbench

Parametrised successor to the Total_ALU datapath. It executes single-cycle logic and arithmetic ops and sequential unsigned multiply/divide into HI/LO registers, with an explicit start/busy/done handshake. MFHI and MFLO read those registers back. It sits between the operand fetch stage and the writeback mux, using the same 6-bit funct-style op encoding.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_seq_muldiv.sv | 96 +++++++++
 rtl/hilo_muldiv_alu.sv | 117 +++++++++++
 tb/tb_hilo_muldiv_alu.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, FSM state and engine mode for hilo_muldiv_alu.
// MULTU decoding depends on the ALU_MULTU_EN macro in the RTL files.
package alu_pkg;

    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_DIVU  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_SLT   = 6'd42;

    typedef enum logic {IDLE, RUN} state_e;

    typedef enum logic {MODE_MUL, MODE_DIV} mode_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative shift-add multiply / restoring divide engine.
// The multiply datapath exists only when ALU_MULTU_EN is defined.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_go,
    input  mode_e            i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);

    state_e             r_state;
    state_e             w_next;
    mode_e              r_mode;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_step;
`ifdef ALU_MULTU_EN
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
`endif

    // acc = {remainder, quotient}; quotient bits shift in from the right
    always_comb begin
        w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff   = w_rem_sh - {1'b0, r_b};
        if (w_diff[WIDTH])
            w_div_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        else
            w_div_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
`ifdef ALU_MULTU_EN
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_step     = (r_mode == MODE_MUL) ? w_mul_step : w_div_step;
`else
        w_step     = (r_mode == MODE_DIV) ? w_div_step : r_acc;
`endif
    end

    always_comb begin
        w_next = r_state;
        o_last = 1'b0;
        unique case (r_state)
            IDLE: if (i_go) w_next = RUN;
            RUN: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    o_last = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= MODE_DIV;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_go) begin
                r_mode <= i_mode;
                r_b    <= i_b;
                r_acc  <= {{WIDTH{1'b0}}, i_a};
                r_cnt  <= '0;
            end else if (r_state == RUN) begin
                r_acc <= w_step;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_busy = (r_state == RUN);
    assign o_hi   = w_step[2*WIDTH-1:WIDTH];
    assign o_lo   = w_step[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv_alu.sv
// hilo_muldiv_alu: single-cycle ALU ops plus sequential MULTU/DIVU into HI/LO.
// Define ALU_MULTU_EN to include MULTU; otherwise opcode 25 is an unknown op.
module hilo_muldiv_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             divByZero
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH-1:0] w_res;
    logic             w_go;
    logic             w_hold;
    logic             w_div0;
    mode_e            w_mode;
    logic             w_accept;
    logic             w_busy;
    logic             w_last;
    logic [WIDTH-1:0] w_eng_hi;
    logic [WIDTH-1:0] w_eng_lo;

    assign w_accept = start && !w_busy;

    // w_hold marks ops whose results go to HI/LO, leaving dataOut untouched
    always_comb begin
        w_res  = '0;
        w_go   = 1'b0;
        w_hold = 1'b0;
        w_div0 = 1'b0;
        w_mode = MODE_DIV;
        unique case (signal)
            OP_AND:  w_res = dataA & dataB;
            OP_OR:   w_res = dataA | dataB;
            OP_ADD:  w_res = dataA + dataB;
            OP_SUB:  w_res = dataA - dataB;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}},
                              $signed(dataA) < $signed(dataB)};
            OP_SRL:  w_res = dataA >> dataB[SHAMT_W-1:0];
            OP_MFHI: w_res = r_hi;
            OP_MFLO: w_res = r_lo;
`ifdef ALU_MULTU_EN
            OP_MULTU: begin
                w_hold = 1'b1;
                w_go   = 1'b1;
                w_mode = MODE_MUL;
            end
`endif
            OP_DIVU: begin
                w_hold = 1'b1;
                if (dataB == '0) w_div0 = 1'b1;
                else             w_go   = 1'b1;
            end
            default: w_res = '0;
        endcase
    end

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_seq (
        .clk    (clk),
        .reset  (reset),
        .i_go   (w_accept && w_go),
        .i_mode (w_mode),
        .i_a    (dataA),
        .i_b    (dataB),
        .o_busy (w_busy),
        .o_last (w_last),
        .o_hi   (w_eng_hi),
        .o_lo   (w_eng_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_last) begin
                r_hi   <= w_eng_hi;
                r_lo   <= w_eng_lo;
                r_done <= 1'b1;
            end
            if (w_accept) begin
                r_dbz <= w_div0;
                if (!w_go)   r_done <= 1'b1;
                if (!w_hold) r_out  <= w_res;
                if (w_div0) begin
                    r_hi <= dataA;
                    r_lo <= '1;
                end
            end
        end
    end

    assign dataOut   = r_out;
    assign busy      = w_busy;
    assign done      = r_done;
    assign divByZero = r_dbz;

endmodule

// File: tb/tb_hilo_muldiv_alu.sv
// tb_hilo_muldiv_alu: scoreboard bench for hilo_muldiv_alu at WIDTH=32.
// MULTU expectations follow ALU_MULTU_EN.
module tb_hilo_muldiv_alu;

    localparam logic [5:0] C_SRL  = 6'd2;
    localparam logic [5:0] C_MFHI = 6'd16;
    localparam logic [5:0] C_MFLO = 6'd18;
    localparam logic [5:0] C_MULT = 6'd25;
    localparam logic [5:0] C_DIVU = 6'd27;
    localparam logic [5:0] C_ADD  = 6'd32;
    localparam logic [5:0] C_SUB  = 6'd34;
    localparam logic [5:0] C_AND  = 6'd36;
    localparam logic [5:0] C_SLT  = 6'd42;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  signal = '0;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;
    logic        divByZero;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    hilo_muldiv_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signal    (signal),
        .dataA     (dataA),
        .dataB     (dataB),
        .dataOut   (dataOut),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [5:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        signal = op;
        dataA  = a;
        dataB  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got none required entry");
            e = 'x;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({dataOut, busy, done, divByZero} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%b%b%b required 0", dataOut,
                     busy, done, divByZero);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'd0);
        issue(C_MFHI, 32'd0, 32'd0);
        pop_exp();
        n_tests++;
        if (dataOut !== e) begin
            n_fail++;
            $display("FAIL reset_hi: got %h required %h", dataOut, e);
        end
    endtask

    task automatic test_arith();
        logic [5:0]  ops[4];
        logic [31:0] as[4];
        logic [31:0] bs[4];
        ops = '{C_ADD, C_SUB, C_SLT, C_AND};
        as  = '{32'd7, 32'd5, 32'hFFFF_FFFF, 32'h0000_F0F0};
        bs  = '{32'd5, 32'd7, 32'd1, 32'h0000_FF00};
        exp_q.push_back(32'd12);
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'h0000_F000);
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            pop_exp();
            n_tests++;
            if (done !== 1'b1 || dataOut !== e) begin
                n_fail++;
                $display("FAIL arith_%0d: got %h done=%b required %h done=1",
                         i, dataOut, done, e);
            end
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_end: got %b required 0", done);
        end
    endtask

    task automatic test_srl();
        exp_q.push_back(32'd1);
        issue(C_SRL, 32'h8000_0000, 32'd31);
        pop_exp();
        n_tests++;
        if (dataOut !== e) begin
            n_fail++;
            $display("FAIL srl_31: got %h required %h", dataOut, e);
        end
        exp_q.push_back(32'h4000_0000);
        issue(C_SRL, 32'h8000_0000, 32'd33);
        pop_exp();
        n_tests++;
        if (dataOut !== e) begin
            n_fail++;
            $display("FAIL srl_33: got %h required %h", dataOut, e);
        end
        exp_q.push_back(32'd0);
        issue(6'd50, 32'h1234_5678, 32'h1);
        pop_exp();
        n_tests++;
        if (dataOut !== e || done !== 1'b1) begin
            n_fail++;
            $display("FAIL unknown_op: got %h done=%b required %h done=1",
                     dataOut, done, e);
        end
    endtask

    task automatic test_divu();
        int n;
        logic [31:0] held;
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd14);
        held = dataOut;
        issue(C_DIVU, 32'd100, 32'd7);
        start  = 1'b1;
        signal = C_ADD;
        dataA  = 32'd9;
        dataB  = 32'd9;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 5) start = 1'b0;
            n_tests++;
            if (done !== 1'b0 || dataOut !== held) begin
                n_fail++;
                $display("FAIL divu_busy_%0d: got done=%b out=%h required 0/%h",
                         n, done, dataOut, held);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        n_tests++;
        if (n != 32 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL divu_latency: got %0d cycles done=%b required 32 done=1",
                     n, done);
        end
        issue(C_MFHI, 32'd0, 32'd0);
        pop_exp();
        n_tests++;
        if (dataOut !== e) begin
            n_fail++;
            $display("FAIL divu_hi: got %h required %h", dataOut, e);
        end
        issue(C_MFLO, 32'd0, 32'd0);
        pop_exp();
        n_tests++;
        if (dataOut !== e) begin
            n_fail++;
            $display("FAIL divu_lo: got %h required %h", dataOut, e);
        end
    endtask

    task automatic test_div0();
        logic [31:0] held;
        held = dataOut;
        issue(C_DIVU, 32'd5, 32'd0);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || divByZero !== 1'b1 ||
            dataOut !== held) begin
            n_fail++;
            $display("FAIL div0_flags: got d=%b b=%b z=%b out=%h required 1/0/1/%h",
                     done, busy, divByZero, dataOut, held);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (divByZero !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_sticky: got %b required 1", divByZero);
        end
        exp_q.push_back(32'd3);
        issue(C_ADD, 32'd1, 32'd2);
        pop_exp();
        n_tests++;
        if (divByZero !== 1'b0 || dataOut !== e) begin
            n_fail++;
            $display("FAIL div0_clear: got z=%b out=%h required 0/%h",
                     divByZero, dataOut, e);
        end
        exp_q.push_back(32'd5);
        issue(C_MFHI, 32'd0, 32'd0);
        pop_exp();
        n_tests++;
        if (dataOut !== e) begin
            n_fail++;
            $display("FAIL div0_hi: got %h required %h", dataOut, e);
        end
        exp_q.push_back(32'hFFFF_FFFF);
        issue(C_MFLO, 32'd0, 32'd0);
        pop_exp();
        n_tests++;
        if (dataOut !== e) begin
            n_fail++;
            $display("FAIL div0_lo: got %h required %h", dataOut, e);
        end
    endtask

    task automatic test_multu();
        int n;
`ifdef ALU_MULTU_EN
        exp_q.push_back(32'd1);
        exp_q.push_back(32'hFFFF_FFFE);
        issue(C_MULT, 32'hFFFF_FFFF, 32'd2);
        dataA = 32'd0;
        dataB = 32'd0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (n != 32 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL multu_latency: got %0d cycles done=%b required 32 done=1",
                     n, done);
        end
`else
        exp_q.push_back(32'd5);
        exp_q.push_back(32'hFFFF_FFFF);
        n = 0;
        issue(C_MULT, 32'hFFFF_FFFF, 32'd2);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b1 || dataOut !== 32'd0) begin
            n_fail++;
            $display("FAIL multu_off: got b=%b d=%b out=%h required 0/1/0",
                     busy, done, dataOut);
        end
`endif
        issue(C_MFHI, 32'd0, 32'd0);
        pop_exp();
        n_tests++;
        if (dataOut !== e) begin
            n_fail++;
            $display("FAIL multu_hi: got %h required %h", dataOut, e);
        end
        issue(C_MFLO, 32'd0, 32'd0);
        pop_exp();
        n_tests++;
        if (dataOut !== e) begin
            n_fail++;
            $display("FAIL multu_lo: got %h required %h", dataOut, e);
        end
    endtask

    task automatic test_reset_mid();
        issue(C_DIVU, 32'd1000, 32'd3);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || dataOut !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got b=%b d=%b out=%h required 0/0/0",
                     busy, done, dataOut);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        issue(C_MFHI, 32'd0, 32'd0);
        pop_exp();
        n_tests++;
        if (dataOut !== e) begin
            n_fail++;
            $display("FAIL reset_mid_hi: got %h required %h", dataOut, e);
        end
        issue(C_MFLO, 32'd0, 32'd0);
        pop_exp();
        n_tests++;
        if (dataOut !== e || done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_lo: got %h done=%b required %h done=1",
                     dataOut, done, e);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_srl();
        test_divu();
        test_div0();
        test_multu();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: got %0d entries required 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
